// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-sequence game control unit:
// state codes, which also drive the hex debug display, and the per-state output decode.
package jogo_pkg;

  localparam int unsigned ESTADO_W              = 4;
  localparam int unsigned TIMEOUT_CYCLES_PADRAO = 3000;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_contagem;
    logic conta_contagem;
    logic zera_registrador;
    logic registra_registrador;
    logic acertou;
    logic errou;
    logic timeout;
    logic pronto;
    logic zera_timer;
    logic conta_timer;
  } saidas_t;

  // Moore decode: every control output is a pure function of the state.
  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zera_contagem    = 1'b1;
        s.zera_registrador = 1'b1;
        s.zera_timer       = 1'b1;
      end
      ESPERA:   s.conta_timer          = 1'b1;
      REGISTRA: s.registra_registrador = 1'b1;
      PROXIMO: begin
        s.conta_contagem = 1'b1;
        s.zera_timer     = 1'b1;
      end
      FIM_ACERTO: begin
        s.acertou = 1'b1;
        s.pronto  = 1'b1;
      end
      FIM_ERRO: begin
        s.errou  = 1'b1;
        s.pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.timeout = 1'b1;
        s.pronto  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Inactivity timer: counts while enabled, flags the last allowed cycle and
// saturates there, so it never wraps back into the valid range.
module contador_timeout
  import jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_PADRAO,
  parameter int unsigned TIMER_WIDTH    = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [TIMER_WIDTH-1:0] ULTIMO = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] valor;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta && (valor != ULTIMO)) begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Control FSM for the memory-sequence game datapath, with a per-play
// inactivity timeout. Outputs are registered alongside the state.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_PADRAO,
  parameter int unsigned TIMER_WIDTH    = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada,
  input  logic                igual,
  input  logic                fim_contagem,
  output logic                zera_contagem,
  output logic                conta_contagem,
  output logic                zera_registrador,
  output logic                registra_registrador,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                pronto,
  output logic [ESTADO_W-1:0] db_estado
);

  estado_t estado, estado_prox;
  saidas_t saidas;
  logic    fim_timer;

  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_WIDTH   (TIMER_WIDTH)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .zera (saidas.zera_timer),
    .conta(saidas.conta_timer),
    .fim  (fim_timer)
  );

  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL:    estado_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: estado_prox = ESPERA;
      // A play on the last allowed cycle takes priority over the timeout.
      ESPERA: begin
        if (jogada)         estado_prox = REGISTRA;
        else if (fim_timer) estado_prox = FIM_TIMEOUT;
        else                estado_prox = ESPERA;
      end
      REGISTRA: estado_prox = COMPARA;
      COMPARA: begin
        if (!igual)            estado_prox = FIM_ERRO;
        else if (fim_contagem) estado_prox = FIM_ACERTO;
        else                   estado_prox = PROXIMO;
      end
      PROXIMO:    estado_prox = ESPERA;
      FIM_ACERTO: estado_prox = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:   estado_prox = iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT: estado_prox = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:    estado_prox = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= estado_prox;
      saidas <= decodifica(estado_prox);
    end
  end

  assign zera_contagem        = saidas.zera_contagem;
  assign conta_contagem       = saidas.conta_contagem;
  assign zera_registrador     = saidas.zera_registrador;
  assign registra_registrador = saidas.registra_registrador;
  assign acertou              = saidas.acertou;
  assign errou                = saidas.errou;
  assign timeout              = saidas.timeout;
  assign pronto               = saidas.pronto;
  assign db_estado            = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo: directed game scenarios plus
// randomized play, each cycle checked against a behavioural game model.
module tb_unidade_controle_jogo;

  localparam int unsigned TO = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fim_contagem = 1'b0;
  logic       zera_contagem, conta_contagem, zera_registrador, registra_registrador;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  // Game model: displayed phase code and how many cycles the player has waited.
  int m_st = 0;
  int m_espera = 0;

  unidade_controle_jogo #(
    .TIMEOUT_CYCLES(TO),
    .TIMER_WIDTH   (6)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .jogada              (jogada),
    .igual               (igual),
    .fim_contagem        (fim_contagem),
    .zera_contagem       (zera_contagem),
    .conta_contagem      (conta_contagem),
    .zera_registrador    (zera_registrador),
    .registra_registrador(registra_registrador),
    .acertou             (acertou),
    .errou               (errou),
    .timeout             (timeout),
    .pronto              (pronto),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] obs();
    return {zera_contagem, conta_contagem, zera_registrador, registra_registrador,
            acertou, errou, timeout, pronto, db_estado};
  endfunction

  function automatic logic [11:0] esp();
    logic fa, fe, ft;
    fa = (m_st == 10);
    fe = (m_st == 14);
    ft = (m_st == 13);
    return {(m_st == 1), (m_st == 6), (m_st == 1), (m_st == 4),
            fa, fe, ft, (fa | fe | ft), 4'(m_st)};
  endfunction

  task automatic modelo(input logic i, input logic j, input logic ig, input logic f);
    case (m_st)
      0:          if (i) m_st = 1;
      1:          begin m_st = 2; m_espera = 0; end
      2: begin
        if (j) m_st = 4;
        else if (m_espera == int'(TO) - 1) m_st = 13;
        else m_espera++;
      end
      4:          m_st = 5;
      5:          m_st = !ig ? 14 : (f ? 10 : 6);
      6:          begin m_st = 2; m_espera = 0; end
      10, 13, 14: if (i) m_st = 1;
      default:    m_st = 0;
    endcase
  endtask

  task automatic ciclo(input logic i, input logic j, input logic ig, input logic f);
    @(negedge clock);
    iniciar = i; jogada = j; igual = ig; fim_contagem = f;
    @(posedge clock);
    modelo(i, j, ig, f);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs() !== 12'h000) begin
      n_err++; $display("FAIL reset_inicial: obtido=%h esperado=%h", obs(), 12'h000);
    end
    @(negedge clock);
    reset = 1'b1;
    m_st = 0;
    for (int k = 0; k < 4; k++) begin
      ciclo(k < 2, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs() !== esp()) begin
        n_err++; $display("FAIL reset_pre: obtido=%h esperado=%h", obs(), esp());
      end
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 12'h000) begin
      n_err++; $display("FAIL reset_assincrono: obtido=%h esperado=%h", obs(), 12'h000);
    end
    @(negedge clock);
    iniciar = 0; jogada = 0; igual = 0; fim_contagem = 0;
    reset = 1'b1;
    m_st = 0; m_espera = 0;
  endtask

  task automatic test_jogo_correto();
    int nz = 0;
    int nc = 0;
    for (int k = 1; k <= 5 + 16 * 20; k++) begin
      int p;
      logic j, f;
      p = k - 6;
      j = (p >= 0) && (p % 20 == 0);
      f = (p >= 15 * 20);
      ciclo(k <= 5, j, 1'b1, f);
      nz += int'(zera_contagem);
      nc += int'(conta_contagem);
      n_cmp++;
      if (obs() !== esp()) begin
        n_err++; $display("FAIL jogo_correto ciclo %0d: obtido=%h esperado=%h", k, obs(), esp());
      end
    end
    n_cmp++;
    if (nz !== 1) begin n_err++; $display("FAIL correto_zera: obtido=%0d esperado=1", nz); end
    n_cmp++;
    if (nc !== 15) begin n_err++; $display("FAIL correto_conta: obtido=%0d esperado=15", nc); end
    n_cmp++;
    if ({acertou, pronto, db_estado} !== {1'b1, 1'b1, 4'hA}) begin
      n_err++; $display("FAIL correto_fim: obtido=%b%b%h esperado=11a", acertou, pronto, db_estado);
    end
  endtask

  task automatic test_reinicio_e_erro();
    int nz = 0;
    int nc = 0;
    for (int k = 0; k < 5; k++) begin
      ciclo(1'b1, 1'b0, 1'b1, 1'b0);
      nz += int'(zera_contagem);
      n_cmp++;
      if (obs() !== esp()) begin
        n_err++; $display("FAIL reinicio ciclo %0d: obtido=%h esperado=%h", k, obs(), esp());
      end
    end
    n_cmp++;
    if (nz !== 1) begin n_err++; $display("FAIL reinicio_zera: obtido=%0d esperado=1", nz); end
    n_cmp++;
    if ({db_estado, acertou, pronto} !== {4'h2, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reinicio_espera: obtido=%h%b%b esperado=200", db_estado, acertou, pronto);
    end
    for (int p = 1; p <= 3; p++) begin
      for (int k = 0; k < 10; k++) begin
        ciclo(1'b0, k == 0, p != 3, 1'b0);
        nc += int'(conta_contagem);
        n_cmp++;
        if (obs() !== esp()) begin
          n_err++; $display("FAIL erro jogada %0d ciclo %0d: obtido=%h esperado=%h", p, k, obs(), esp());
        end
      end
    end
    n_cmp++;
    if (nc !== 2) begin n_err++; $display("FAIL erro_conta: obtido=%0d esperado=2", nc); end
    n_cmp++;
    if ({errou, pronto, db_estado} !== {1'b1, 1'b1, 4'hE}) begin
      n_err++; $display("FAIL erro_fim: obtido=%b%b%h esperado=11e", errou, pronto, db_estado);
    end
  endtask

  // Restart, make two correct plays, and leave the game waiting in ESPERA.
  task automatic dois_acertos();
    ciclo(1'b1, 1'b0, 1'b1, 1'b0);
    ciclo(1'b0, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      ciclo(1'b0, 1'b1, 1'b1, 1'b0);
      for (int t = 0; t < 10 && db_estado != 4'h2; t++) ciclo(1'b0, 1'b0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (obs() !== esp() || db_estado !== 4'h2) begin
      n_err++; $display("FAIL dois_acertos: obtido=%h esperado=%h", obs(), esp());
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    dois_acertos();
    while (db_estado != 4'hD && n < int'(TO) + 5) begin
      ciclo(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
      n_cmp++;
      if (obs() !== esp()) begin
        n_err++; $display("FAIL timeout ciclo %0d: obtido=%h esperado=%h", n, obs(), esp());
      end
    end
    n_cmp++;
    if (n !== int'(TO)) begin n_err++; $display("FAIL timeout_latencia: obtido=%0d esperado=%0d", n, TO); end
    n_cmp++;
    if ({timeout, pronto} !== 2'b11) begin
      n_err++; $display("FAIL timeout_flags: obtido=%b%b esperado=11", timeout, pronto);
    end
    dois_acertos();
    for (int k = 1; k < int'(TO); k++) ciclo(1'b0, 1'b0, 1'b1, 1'b0);
    ciclo(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({db_estado, timeout} !== {4'h4, 1'b0} || obs() !== esp()) begin
      n_err++; $display("FAIL timeout_ultimo_ciclo: obtido=%h esperado=%h", obs(), esp());
    end
    for (int k = 0; k < 3; k++) ciclo(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ignorados();
    int nr = 0;
    logic [4:0] jog;
    jog = 5'b01011;
    for (int t = 0; t < 10 && db_estado != 4'h2; t++) ciclo(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      ciclo(1'b0, (k < 5) ? jog[k] : 1'b0, 1'b1, 1'b0);
      nr += int'(registra_registrador);
      n_cmp++;
      if (obs() !== esp()) begin
        n_err++; $display("FAIL ignorados ciclo %0d: obtido=%h esperado=%h", k, obs(), esp());
      end
    end
    n_cmp++;
    if (nr !== 1) begin n_err++; $display("FAIL ignorados_registra: obtido=%0d esperado=1", nr); end
    n_cmp++;
    if (db_estado !== 4'h2) begin n_err++; $display("FAIL ignorados_estado: obtido=%h esperado=2", db_estado); end
  endtask

  task automatic test_aleatorio();
    for (int k = 0; k < 4000; k++) begin
      ciclo($urandom_range(15) == 0, $urandom_range(5) == 0,
            $urandom_range(3) != 0, $urandom_range(7) == 0);
      n_cmp++;
      if (obs() !== esp()) begin
        n_err++; $display("FAIL aleatorio ciclo %0d: obtido=%h esperado=%h", k, obs(), esp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_jogo_correto();
    test_reinicio_e_erro();
    test_timeout();
    test_ignorados();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Control unit for the memory-sequence game datapath: an address counter over the 16-entry sequence ROM, a play register, a comparator and a play edge detector. This block sequences that datapath. It clears and advances the counter, loads the play register, and evaluates the comparator result. It also adds a per-play inactivity timeout. The FSM drives the top-level acertou/errou/pronto outputs and the db_estado debug display.

Parameters:
TIMEOUT_CYCLES, 3000, clock cycles allowed in ESPERA before timeout (3 s at 1 kHz)
TIMER_WIDTH, 12, width of the internal timeout counter; must satisfy 2^TIMER_WIDTH > TIMEOUT_CYCLES

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start/restart request, level
jogada  in  1  one-cycle pulse from the play edge detector
igual  in  1  comparator: play register equals memory word
fim_contagem  in  1  address counter at last address (15)
zera_contagem  out  1  synchronous clear of the address counter
conta_contagem  out  1  increment enable of the address counter
zera_registrador  out  1  clear of the play register
registra_registrador  out  1  load enable of the play register
acertou  out  1  game ended, all plays correct
errou  out  1  game ended on a wrong play
timeout  out  1  game ended on inactivity
pronto  out  1  game ended, any cause
db_estado  out  4  current state code for hex display

Behaviour:
- The reset port is asynchronous, active-low, on a single clock domain.
- On reset=0: state INICIAL, timer=0. Every output is 0 and db_estado=0.
- All control outputs are Moore outputs decoded from the state register. There are no Mealy paths.
- State codes: INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=4, COMPARA=5, PROXIMO=6, FIM_ACERTO=A, FIM_TIMEOUT=D, FIM_ERRO=E.
- INICIAL: all outputs 0. When iniciar=1, go to PREPARACAO. Otherwise stay.
- PREPARACAO: lasts 1 cycle, with zera_contagem=1 and zera_registrador=1. Timer clears. Next state is ESPERA.
- ESPERA: the timer increments every cycle.
  - If jogada=1, go to REGISTRA.
  - Else if timer==TIMEOUT_CYCLES-1, go to FIM_TIMEOUT.
  - If jogada and timeout occur in the same cycle, jogada wins.
  - iniciar is ignored in this state.
- REGISTRA: lasts 1 cycle, with registra_registrador=1. Next state is COMPARA.
- COMPARA: lasts 1 cycle and samples igual and fim_contagem.
  - igual=0: go to FIM_ERRO.
  - igual=1 and fim_contagem=1: go to FIM_ACERTO.
  - igual=1 and fim_contagem=0: go to PROXIMO.
- PROXIMO: lasts 1 cycle, with conta_contagem=1. Timer clears. Next state is ESPERA.
- Fixed latency from a jogada pulse to the result decision is 2 cycles (REGISTRA, then COMPARA).
- Latency from a jogada pulse to pronto is 3 clock edges.
- FIM_ACERTO: pronto=1, acertou=1.
- FIM_ERRO: pronto=1, errou=1.
- FIM_TIMEOUT: pronto=1, timeout=1.
- All three FIM states hold until iniciar=1, which goes to PREPARACAO (restart without reset). Each FIM state then clears its flags on that transition.
- If iniciar is held for multiple cycles, only one PREPARACAO occurs. Holding iniciar in ESPERA has no effect.
- A jogada pulse arriving in REGISTRA, COMPARA, PROXIMO, INICIAL or a FIM state is ignored. It is not queued.
- The timer saturates and never wraps. It is only compared while in ESPERA.
- At most one of acertou/errou/timeout is 1 at any time. pronto equals the OR of the three.
- Unused state codes recover to INICIAL on the next clock.
- Reset asserted mid-game: immediate return to INICIAL with outputs 0. The datapath is cleared only by the next PREPARACAO.

Decomposition:
- Package jogo_pkg: state encoding constants (4-bit codes above), the ESTADO_W=4 constant, and the default TIMEOUT_CYCLES.
- One sub-module, contador_timeout: parameterised TIMER_WIDTH up-counter with synchronous zera, conta enable, async active-low reset, and a fim output at TIMEOUT_CYCLES-1 with saturation.
- The FSM lives in unidade_controle_jogo. The FSM drives contador_timeout's zera and conta inputs.

Test Plan:
- Reset values: pulse reset=0 mid-run → all outputs 0, db_estado=0 immediately, before the next clock edge.
- Full correct game: iniciar=1 for 5 cycles, then 16 jogada pulses 20 cycles apart with igual=1 and fim_contagem=1 only on the 16th.
  - Expect exactly 1 zera_contagem pulse and 15 conta_contagem pulses.
  - Expect acertou=1, pronto=1, db_estado=A.
- Error on 3rd play: igual=0 at the 3rd COMPARA → errou=1, pronto=1, db_estado=E, and conta_contagem has pulsed exactly 2 times.
- Timeout: after the 2nd play, no jogada for TIMEOUT_CYCLES cycles.
  - timeout=1 and db_estado=D appear exactly TIMEOUT_CYCLES cycles after ESPERA is entered.
  - A jogada arriving on the final cycle instead gives REGISTRA.
- Restart from FIM_ACERTO with iniciar=1 for 5 cycles → single PREPARACAO (zera_contagem=1 for 1 cycle), then ESPERA, with acertou=0 and pronto=0.
- Ignored inputs: jogada pulse during REGISTRA or PROXIMO → no extra registra_registrador pulse. The state sequence is unchanged.
